// File: rtl/iomem_pwm_leds_pkg.sv
// iomem_pwm_leds_pkg: register offsets, CTRL bit indices, default widths and byte-lane merge helper
package iomem_pwm_leds_pkg;
  localparam int DEF_NCH = 8;
  localparam int DEF_DW = 8;
  localparam int DEF_PSW = 16;
  localparam logic [5:0] OFF_CTRL = 6'h00;
  localparam logic [5:0] OFF_PRESCALE = 6'h01;
  localparam logic [5:0] OFF_PERIOD = 6'h02;
  localparam logic [5:0] OFF_STATUS = 6'h03;
  localparam logic [5:0] OFF_DUTY_BASE = 6'h04;
  localparam int CTRL_EN = 0;
  localparam int CTRL_INV = 1;
  localparam int CTRL_IRQ_EN = 2;
  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wdata,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/iomem_pwm_leds_timebase.sv
// pwm_timebase: prescaler and period counter; the period shadow reloads on wrap or while disabled
module pwm_timebase import iomem_pwm_leds_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int PSW = DEF_PSW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [PSW-1:0] prescale,
  input  logic [DW-1:0]  period,
  output logic           tick,
  output logic           wrap,
  output logic [DW-1:0]  cnt
);
  logic [PSW-1:0] psc_q, psc_d;
  logic [DW-1:0] cnt_q, cnt_d, per_sh_q, per_sh_d;
  always_comb begin
    tick = en && psc_q == prescale;
    wrap = tick && cnt_q >= per_sh_q;
    psc_d = (!en || tick) ? '0 : psc_q + PSW'(1);
    cnt_d = (!en || wrap) ? '0 : tick ? cnt_q + DW'(1) : cnt_q;
    per_sh_d = (!en || wrap) ? period : per_sh_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      psc_q <= '0;
      cnt_q <= '0;
      per_sh_q <= '0;
    end else begin
      psc_q <= psc_d;
      cnt_q <= cnt_d;
      per_sh_q <= per_sh_d;
    end
  assign cnt = cnt_q;
endmodule

// File: rtl/iomem_pwm_leds.sv
// iomem_pwm_leds: iomem-mapped PWM LED driver with double-buffered duty/period.
// Define IOMEM_PWM_LEDS_IRQ_EN to add the STATUS.WRAP flag, CTRL bit2 and the irq port.
module iomem_pwm_leds import iomem_pwm_leds_pkg::*; #(
  parameter int NCH = DEF_NCH,
  parameter int DW = DEF_DW,
  parameter int PSW = DEF_PSW,
  parameter logic [7:0] BASE_SEL = 8'h03
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           iomem_valid,
  output logic           iomem_ready,
  input  logic [3:0]     iomem_wstrb,
  input  logic [31:0]    iomem_addr,
  input  logic [31:0]    iomem_wdata,
  output logic [31:0]    iomem_rdata,
  output logic [NCH-1:0] leds
`ifdef IOMEM_PWM_LEDS_IRQ_EN
  ,
  output logic           irq
`endif
);
`ifdef IOMEM_PWM_LEDS_IRQ_EN
  localparam int CW = 3;
`else
  localparam int CW = 2;
`endif
  logic [CW-1:0] ctrl_q, ctrl_d;
  logic [PSW-1:0] prescale_q, prescale_d;
  logic [DW-1:0] period_q, period_d;
  logic [DW-1:0] duty_q [NCH];
  logic [DW-1:0] duty_d [NCH];
  logic [DW-1:0] duty_sh_q [NCH];
  logic [DW-1:0] duty_sh_d [NCH];
  logic flag_q, flag_d, ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d, rd_val, wr_val;
  logic [NCH-1:0] leds_q, leds_d;
  logic [5:0] off;
  logic sel, wr, en, tick, wrap;
  logic [DW-1:0] cnt;
  logic unused_bits;
  assign unused_bits = ^{iomem_addr[23:8], iomem_addr[1:0], tick};
  pwm_timebase #(.DW(DW), .PSW(PSW)) u_tb (
    .clk(clk), .rst(reset), .en(en), .prescale(prescale_q), .period(period_q),
    .tick(tick), .wrap(wrap), .cnt(cnt)
  );
  always_comb begin
    off = iomem_addr[7:2];
    sel = iomem_valid && !ready_q && iomem_addr[31:24] == BASE_SEL;
    wr = sel && |iomem_wstrb;
    en = ctrl_q[CTRL_EN];
    rd_val = '0;
    if (off == OFF_CTRL) rd_val = 32'(ctrl_q);
    if (off == OFF_PRESCALE) rd_val = 32'(prescale_q);
    if (off == OFF_PERIOD) rd_val = 32'(period_q);
    if (off == OFF_STATUS) rd_val = 32'(flag_q);
    for (int i = 0; i < NCH; i++) if (off == OFF_DUTY_BASE + 6'(i)) rd_val = 32'(duty_q[i]);
    wr_val = byte_merge(rd_val, iomem_wdata, iomem_wstrb);
    ctrl_d = (wr && off == OFF_CTRL) ? CW'(wr_val) : ctrl_q;
    prescale_d = (wr && off == OFF_PRESCALE) ? PSW'(wr_val) : prescale_q;
    period_d = (wr && off == OFF_PERIOD) ? DW'(wr_val) : period_q;
    leds_d = '0;
    for (int i = 0; i < NCH; i++) begin
      duty_d[i] = (wr && off == OFF_DUTY_BASE + 6'(i)) ? DW'(wr_val) : duty_q[i];
      // shadows sample the pre-write register value, so a write landing on a wrap waits a period
      duty_sh_d[i] = (!en || wrap) ? duty_q[i] : duty_sh_q[i];
      leds_d[i] = (en && cnt < duty_sh_q[i]) ^ (en && ctrl_q[CTRL_INV]);
    end
`ifdef IOMEM_PWM_LEDS_IRQ_EN
    flag_d = wrap || (flag_q && !(wr && off == OFF_STATUS && wr_val[0]));
`else
    flag_d = 1'b0;
`endif
    ready_d = sel;
    rdata_d = sel ? rd_val : rdata_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      ctrl_q <= '0;
      prescale_q <= '0;
      period_q <= '0;
      duty_q <= '{default: '0};
      duty_sh_q <= '{default: '0};
      flag_q <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      leds_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      prescale_q <= prescale_d;
      period_q <= period_d;
      duty_q <= duty_d;
      duty_sh_q <= duty_sh_d;
      flag_q <= flag_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      leds_q <= leds_d;
    end
  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign leds = leds_q;
`ifdef IOMEM_PWM_LEDS_IRQ_EN
  assign irq = flag_q && ctrl_q[CTRL_IRQ_EN];
`endif
endmodule

// File: tb/tb_iomem_pwm_leds.sv
// tb_iomem_pwm_leds: directed scoreboard bench for iomem_pwm_leds (bus map, PWM waveforms, double buffering)
module tb_iomem_pwm_leds;
  localparam int NCH = 8;
  localparam logic [31:0] BASE = 32'h0300_0000;
`ifdef IOMEM_PWM_LEDS_IRQ_EN
  localparam logic [31:0] CTRL_MASK = 32'h7;
`else
  localparam logic [31:0] CTRL_MASK = 32'h3;
`endif
  logic clk = 1'b0, reset = 1'b1, iomem_valid = 1'b0, iomem_ready;
  logic [3:0] iomem_wstrb = '0;
  logic [31:0] iomem_addr = '0, iomem_wdata = '0, iomem_rdata;
  logic [NCH-1:0] leds;
`ifdef IOMEM_PWM_LEDS_IRQ_EN
  logic irq;
`endif
  int vectors = 0, miscompares = 0;
  logic [63:0] exp_q[$];
  string tag_q[$];
  logic [NCH-1:0] hist [64];
  logic [63:0] pat, exp_pat;
  logic any_ready;
  bit ok;
  int cnt_ok;

  iomem_pwm_leds #(.NCH(NCH)) dut (
    .clk(clk), .reset(reset), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .leds(leds)
`ifdef IOMEM_PWM_LEDS_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input string tag, input logic [63:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    logic [63:0] e;
    string t;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0h required=entry", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                     input bit chk, input logic [31:0] exp_rd, input string tag);
    logic r1, r2, held;
    logic [31:0] rd;
    expect_val($sformatf("handshake_%s", tag), 64'b101);
    if (chk) expect_val(tag, {32'b0, exp_rd});
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr = addr;
    iomem_wstrb = strb;
    iomem_wdata = wd;
    @(posedge clk);
    #1;
    r1 = iomem_ready;
    rd = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
    @(posedge clk);
    #1;
    r2 = iomem_ready;
    held = iomem_rdata === rd;
    check({61'b0, r1, r2, held});
    if (chk) check({32'b0, rd});
  endtask

  task automatic wr(input logic [5:0] word, input logic [31:0] d);
    bus(BASE | {24'b0, word, 2'b00}, 4'hF, d, 1'b0, '0, $sformatf("wr%0h", word));
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] e, input string tag);
    bus(addr, 4'h0, 32'hDEAD_BEEF, 1'b1, e, tag);
  endtask

  task automatic wait_rise(input int ch, input string tag);
    logic prev;
    bit seen;
    seen = 1'b0;
    expect_val(tag, 64'd1);
    @(negedge clk);
    prev = leds[ch];
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (!prev && leds[ch]) seen = 1'b1;
      prev = leds[ch];
    end
    check({63'b0, seen});
  endtask

  task automatic sample(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      hist[j] = leds;
    end
  endtask

  function automatic logic [63:0] chan(input int ch, input int n);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[j] = hist[j][ch];
    return r;
  endfunction

  // sample j is taken (j+1) cycles after the rising edge at period phase 0
  function automatic logic [63:0] pwm_model(input int n, input int hi, input int per);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[j] = ((j + 1) % per) < hi;
    return r;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    expect_val("reset_outputs", 64'd0);
    check({23'b0, iomem_ready, iomem_rdata, leds});
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) rd(BASE + 32'(4 * i), 32'd0, $sformatf("reset_rd%0d", i));
    expect_val("leds_after_reset", 64'd0);
    check({56'b0, leds});

    bus(BASE | 32'h4, 4'b0010, 32'h0000_AB00, 1'b0, '0, "wr_prescale_lane1");
    rd(BASE | 32'h4, 32'h0000_AB00, "prescale_lane1");
    bus(BASE | 32'h7C, 4'hF, 32'hFFFF_FFFF, 1'b0, '0, "wr_unmapped");
    rd(BASE | 32'h7C, 32'd0, "unmapped_rd");
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr = 32'h0200_0000;
    any_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      any_ready |= iomem_ready;
    end
    iomem_valid = 1'b0;
    expect_val("other_base_ignored", 64'd0);
    check({63'b0, any_ready});

    wr(6'h01, 32'd0);
    wr(6'h02, 32'd9);
    wr(6'h04, 32'd3);
    wr(6'h05, 32'd0);
    wr(6'h06, 32'd15);
    rd(BASE | 32'h00FF_0008, 32'd9, "period_alias");
    wr(6'h00, 32'd1);
    wait_rise(0, "rise_duty3");
    sample(20);
    expect_val("ch0_duty3", pwm_model(20, 3, 10));
    check(chan(0, 20));
    expect_val("ch1_duty0", 64'd0);
    check(chan(1, 20));
    expect_val("ch2_duty15", pwm_model(20, 20, 10));
    check(chan(2, 20));

    wait_rise(0, "rise_before_update");
    fork
      wr(6'h04, 32'd7);
      sample(40);
    join
    exp_pat = '0;
    for (int j = 0; j < 40; j++) exp_pat[j] = ((j + 1) % 10) < ((j + 1) < 10 ? 3 : 7);
    expect_val("duty_double_buffer", exp_pat);
    check(chan(0, 40));

    wr(6'h00, 32'd0);
    wr(6'h01, 32'd4);
    wr(6'h02, 32'd1);
    wr(6'h04, 32'd1);
    wr(6'h00, 32'd1);
    wait_rise(0, "rise_presc4");
    sample(20);
    expect_val("ch0_presc4", pwm_model(20, 5, 10));
    check(chan(0, 20));
    wr(6'h00, 32'd7);
    rd(BASE, CTRL_MASK & 32'd7, "ctrl_mask");
    wr(6'h00, 32'd3);
    sample(20);
    cnt_ok = 0;
    for (int j = 0; j < 20; j++) if (hist[j][2:1] == 2'b01) cnt_ok++;
    expect_val("inv_ch1_ch2", 64'd20);
    check(64'(cnt_ok));
    wait_rise(0, "rise_inv");
    sample(10);
    expect_val("ch0_inv_width", 64'd5);
    check(64'($countones(chan(0, 10))));
    wr(6'h00, 32'd2);
    sample(10);
    cnt_ok = 0;
    for (int j = 0; j < 10; j++) if (hist[j] == '0) cnt_ok++;
    expect_val("disabled_leds", 64'd10);
    check(64'(cnt_ok));
    rd(BASE | 32'hC, 32'd0, "status_idle");

`ifdef IOMEM_PWM_LEDS_IRQ_EN
    wr(6'h00, 32'd0);
    wr(6'h02, 32'd3);
    wr(6'h01, 32'd0);
    wr(6'h00, 32'd5);
    ok = 1'b0;
    expect_val("irq_rise", 64'd1);
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = irq;
    end
    check({63'b0, ok});
    wr(6'h00, 32'd0);
    rd(BASE | 32'hC, 32'd1, "status_set");
    wr(6'h03, 32'd1);
    rd(BASE | 32'hC, 32'd0, "status_cleared");
    expect_val("irq_cleared", 64'd0);
    check({63'b0, irq});
    wr(6'h02, 32'd0);
    wr(6'h00, 32'd5);
    wr(6'h03, 32'd1);
    rd(BASE | 32'hC, 32'd1, "clear_vs_wrap");
    expect_val("irq_after_clear_vs_wrap", 64'd1);
    check({63'b0, irq});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/iomem_pwm_leds.md
Name: iomem_pwm_leds

Overview:
Memory-mapped PWM LED driver on the PicoSoC iomem bus, decoded at iomem_addr[31:24] == BASE_SEL. It replaces the plain GPIO latch in the board top and drives the leds pins directly. Each of NCH channels gets an independent duty cycle against a shared prescaled period counter. Duty and period writes are double-buffered so they only take effect at period boundaries.

Parameters:
NCH, 8, number of LED channels (1..16)
DW, 8, duty/period counter width
PSW, 16, prescaler width
BASE_SEL, 8'h03, value of iomem_addr[31:24] that selects this block

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
iomem_valid  input  1  bus request
iomem_ready  output  1  one-cycle completion pulse
iomem_wstrb  input  4  byte write strobes; 0 = read
iomem_addr  input  32  byte address
iomem_wdata  input  32  write data
iomem_rdata  output  32  read data, valid while iomem_ready = 1
leds  output  NCH  PWM outputs
irq  output  1  period-wrap interrupt; exists only with IOMEM_PWM_LEDS_IRQ_EN

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. All state updates on posedge clk.
- Values on reset: iomem_ready=0, iomem_rdata=0, leds=0, irq=0. All registers, shadow registers and counters = 0.
- Register map (word offset = addr[7:2]; bits addr[23:8] are ignored):
  - 0x00 CTRL: bit0 EN, bit1 INV (invert outputs).
  - 0x04 PRESCALE: [PSW-1:0].
  - 0x08 PERIOD: [DW-1:0].
  - 0x0C STATUS: bit0 WRAP flag.
  - 0x10 + 4*i DUTY[i]: [DW-1:0], for i < NCH.
  - Register fields are zero-extended on read.
- Handshake:
  - Select condition: iomem_valid && !iomem_ready && addr[31:24] == BASE_SEL.
  - On select, iomem_ready=1 on the next edge and stays high for exactly one cycle. This gives 1-cycle latency, back-to-back accesses every 2 cycles.
  - Writes honour wstrb per byte.
  - Unmapped offsets still complete: rdata=0, writes ignored.
  - Unselected cycles: iomem_ready=0, rdata holds its last value.
- Prescaler: psc counts 0..PRESCALE. A tick is generated when psc == PRESCALE, and psc then returns to 0. PRESCALE=0 gives a tick every cycle.
- Period counter:
  - cnt advances on each tick.
  - When a tick arrives with cnt >= per_sh, cnt wraps to 0. This is the wrap event.
  - On the wrap event, the shadows load from the active registers: per_sh <= PERIOD, duty_sh[i] <= DUTY[i].
  - PERIOD=0 means a wrap on every tick.
- Output: raw[i] = EN && (cnt < duty_sh[i]); leds[i] = raw[i] ^ (INV && EN). Outputs are registered, so they trail cnt by one cycle.
  - duty 0 → always 0.
  - duty > per_sh → always 1.
- Disable (EN=0): psc and cnt held at 0, leds=0 regardless of INV, and shadows load every cycle from the active registers. Re-enabling starts a clean period with no stale shadow values.
- Simultaneous bus write of DUTY/PERIOD and a wrap event: the shadow takes the old register value; the new value applies at the next wrap.
- Reset asserted mid-transaction: iomem_ready drops to 0 on the next edge; that access is lost.

Optional Feature:
IOMEM_PWM_LEDS_IRQ_EN.
- Defined:
  - Every wrap event sets STATUS.WRAP.
  - irq = STATUS.WRAP && CTRL bit2 (IRQ enable). CTRL bit2 is read/write only when the macro is defined.
  - Writing 1 to STATUS bit0 clears the flag. If a clear and a wrap happen in the same cycle, the flag stays set.
- Undefined: the irq port is absent, STATUS reads 0, and CTRL bit2 reads 0 and ignores writes.

Decomposition:
- Shared package iomem_pwm_leds_pkg holds:
  - register offset constants (CTRL, PRESCALE, PERIOD, STATUS, DUTY_BASE);
  - CTRL bit indices;
  - default widths.
- One sub-module, pwm_timebase: contains the prescaler and period counter, and outputs the tick, the wrap pulse and cnt. The duty comparators and bus decode stay in the top.

Test Plan:
- Reset, then read all registers at 0x03000000–0x0300002C → every read returns 0; iomem_ready is a single-cycle pulse 1 cycle after valid; leds=0.
- PRESCALE=0, PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=15, EN=1 → leds[0] high for 3 of every 10 cycles; leds[1] constant 0; leds[2] constant 1.
- While running with DUTY0=3, write DUTY0=7 mid-period → duty stays 3 until the next wrap, then 7; no period shows a value between the two.
- PRESCALE=4, PERIOD=1, DUTY0=1 → leds[0] period is 10 clk, high for 5; then set INV → leds[0] low for 5 of 10; then EN=0 → leds=0.
- Write byte lane 1 only (wstrb=4'b0010, wdata=32'h0000AB00) to PRESCALE → reads back 32'h0000AB00. Write to offset 0x7C → read returns 0 and ready still pulses.
- IOMEM_PWM_LEDS_IRQ_EN: PERIOD=3, PRESCALE=0, CTRL=5 → irq rises 4 cycles after enable; writing STATUS=1 clears it; a clear landing on a wrap cycle leaves irq=1.
